// File: rtl/ldwt_stream.sv
`default_nettype none
// ============================================================================
//  Module   : ldwt_stream
//  Purpose  : Multi-channel streaming lifting DWT stage (lifting or Haar).
//             Per-channel even/odd pairing feeds a stallable pipeline that
//             emits one approximation/detail pair per completed pair.
//  Revision : 1.0  initial release
// ============================================================================
module ldwt_stream #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int FRAC     = 15,
    parameter int P_COEF   = 16384,
    parameter int U_COEF   = 8192,
    parameter int K_COEF   = 23170
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_d,
    output logic [CH_W-1:0]   out_ch
);

    // Intermediate width (d1/a1/sums) and full product width
    localparam int IW    = DATA_W + 2;
    localparam int PW    = IW + FRAC + 1;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [PW-1:0] c_P    = PW'(P_COEF);
    localparam logic signed [PW-1:0] c_U    = PW'(U_COEF);
    localparam logic signed [PW-1:0] c_K    = PW'(K_COEF);
    localparam logic signed [PW-1:0] c_SMAX = PW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] c_SMIN = PW'(-(2 ** (DATA_W - 1)));

    // (v * coef) >>> FRAC, truncated back to intermediate width
    function automatic logic signed [IW-1:0] lift(input logic signed [IW-1:0] v,
                                                  input logic signed [PW-1:0] coef);
        logic signed [PW-1:0] prod;
        prod = (PW'(v) * coef) >>> FRAC;
        return prod[IW-1:0];
    endfunction

    // (v * K) >>> FRAC, clamped to the output range
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [IW-1:0] v);
        logic signed [PW-1:0] sh;
        sh = (PW'(v) * c_K) >>> FRAC;
        if (sh > c_SMAX)      sh = c_SMAX;
        else if (sh < c_SMIN) sh = c_SMIN;
        return sh[DATA_W-1:0];
    endfunction

    // Per-channel lifting state; phase 1 means an odd sample is expected next
    logic              r_phase [CHANNELS];
    logic              r_have  [CHANNELS];
    logic [DATA_W-1:0] r_even  [CHANNELS];
    logic [DATA_W-1:0] r_odd   [CHANNELS];
    logic [IW-1:0]     r_d1p   [CHANNELS];
    logic              r_mode_q;

    // Pipeline: r0 = issued operands, r1 = a1, r2 = scaled d
    logic                 r0_v, r1_v, r2_v;
    logic                 r0_haar;
    logic [CH_W-1:0]      r0_ch, r1_ch, r2_ch;
    logic signed [IW-1:0] r0_e, r0_d, r0_dp;
    logic signed [IW-1:0] r1_a1, r1_d, r2_a1;
    logic [DATA_W-1:0]    r2_d;

    logic                 w_clear, w_inrange, w_acc, w_issue;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_phase, w_have;
    logic [DATA_W-1:0]    w_even, w_odd;
    logic signed [IW-1:0] w_d1p, w_x, w_e, w_o, w_d1;
    logic signed [IW-1:0] w_op_e, w_op_d, w_op_dp;

    assign in_ready  = out_ready || !out_valid;
    assign w_clear   = (mode != r_mode_q);
    assign w_inrange = ({{(32 - CH_W){1'b0}}, in_ch} < 32'(CHANNELS));
    assign w_idx     = IDX_W'(in_ch);
    assign w_acc     = in_valid && in_ready && w_inrange;

    // A mode change makes the accepted sample see freshly cleared state
    assign w_phase = w_clear ? 1'b0 : r_phase[w_idx];
    assign w_have  = w_clear ? 1'b0 : r_have[w_idx];
    assign w_d1p   = w_clear ? '0   : r_d1p[w_idx];
    assign w_even  = r_even[w_idx];
    assign w_odd   = r_odd[w_idx];

    assign w_x  = {{2{in_data[DATA_W-1]}}, in_data};
    assign w_e  = {{2{w_even[DATA_W-1]}}, w_even};
    assign w_o  = {{2{w_odd[DATA_W-1]}}, w_odd};
    assign w_d1 = w_o - lift(w_e + w_x, c_P);

    // Select the operands that enter the pipeline for this sample
    always_comb begin
        w_issue = w_acc && !w_phase && w_have;
        w_op_e  = w_e;
        w_op_d  = w_d1;
        w_op_dp = w_d1p;
        if (mode) begin
            w_issue = w_acc && w_phase;
            w_op_e  = w_e + w_x;
            w_op_d  = w_x - w_e;
            w_op_dp = '0;
        end
    end

    // Per-channel pairing state and the registered mode
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mode_q <= mode;
            for (int i = 0; i < CHANNELS; i++) begin
                r_phase[i] <= 1'b0;
                r_have[i]  <= 1'b0;
                r_d1p[i]   <= '0;
            end
        end else begin
            r_mode_q <= mode;
            if (w_clear) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    r_phase[i] <= 1'b0;
                    r_have[i]  <= 1'b0;
                    r_d1p[i]   <= '0;
                end
            end
            if (w_acc) begin
                if (!w_phase) begin
                    r_even[w_idx]  <= in_data;
                    r_phase[w_idx] <= 1'b1;
                    r_have[w_idx]  <= 1'b0;
                    if (w_issue && !mode) r_d1p[w_idx] <= w_d1;
                end else begin
                    r_odd[w_idx]   <= in_data;
                    r_phase[w_idx] <= 1'b0;
                    r_have[w_idx]  <= !mode;
                end
            end
        end
    end

    // Stallable coefficient pipeline; everything holds while in_ready is low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r0_v      <= 1'b0;
            r1_v      <= 1'b0;
            r2_v      <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_d     <= '0;
            out_ch    <= '0;
        end else if (in_ready) begin
            r0_v    <= w_issue;
            r0_haar <= mode;
            r0_ch   <= in_ch;
            r0_e    <= w_op_e;
            r0_d    <= w_op_d;
            r0_dp   <= w_op_dp;

            r1_v  <= r0_v;
            r1_ch <= r0_ch;
            r1_d  <= r0_d;
            r1_a1 <= r0_haar ? r0_e : r0_e + lift(r0_d + r0_dp, c_U);

            r2_v  <= r1_v;
            r2_ch <= r1_ch;
            r2_a1 <= r1_a1;
            r2_d  <= scale_sat(r1_d);

            out_valid <= r2_v;
            if (r2_v) begin
                out_a  <= scale_sat(r2_a1);
                out_d  <= r2_d;
                out_ch <= r2_ch;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldwt_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldwt_stream
//  Purpose  : Self-checking bench for ldwt_stream: directed vector table,
//             hand-written corner sequences and randomized traffic against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ldwt_stream;

    localparam int     DATA_W   = 16;
    localparam int     CHANNELS = 4;
    localparam int     CH_W     = 3;
    localparam int     FRAC     = 15;
    localparam longint P        = 16384;
    localparam longint U        = 8192;
    localparam longint K        = 23170;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              mode      = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] in_data   = '0;
    logic [CH_W-1:0]   in_ch     = '0;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_a, out_d;
    logic [CH_W-1:0]   out_ch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldwt_stream #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .CH_W(CH_W), .FRAC(FRAC),
        .P_COEF(16384), .U_COEF(8192), .K_COEF(23170)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_d(out_d), .out_ch(out_ch)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int a; int d; int ch; } res_t;
    res_t   expq[$];
    longint hist[CHANNELS][$];
    longint d1p[CHANNELS];
    logic   m_mode_q;

    function automatic longint fl(input longint v);
        longint q = longint'(1) << FRAC;
        if (v >= 0) return v / q;
        return -((-v + q - 1) / q);
    endfunction

    function automatic int sat(input longint v);
        longint mx = (longint'(1) << (DATA_W - 1)) - 1;
        if (v > mx) return int'(mx);
        if (v < -mx - 1) return int'(-mx - 1);
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++) begin
            hist[c].delete();
            d1p[c] = 0;
        end
    endtask

    task automatic model_push(input int c, input longint x, input logic m);
        res_t   r;
        longint e0, o, e1, d1, a1;
        hist[c].push_back(x);
        r.ch = c;
        if (m) begin
            if (hist[c].size() == 2) begin
                e0 = hist[c][0]; o = hist[c][1];
                r.a = sat(fl((e0 + o) * K));
                r.d = sat(fl((o - e0) * K));
                expq.push_back(r);
                hist[c].delete();
            end
        end else if (hist[c].size() == 3) begin
            e0 = hist[c][0]; o = hist[c][1]; e1 = hist[c][2];
            d1 = o - fl(P * (e0 + e1));
            a1 = e0 + fl(U * (d1 + d1p[c]));
            d1p[c] = d1;
            r.a = sat(fl(a1 * K));
            r.d = sat(fl(d1 * K));
            expq.push_back(r);
            hist[c].delete();
            hist[c].push_back(e1);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit                prev_stall   = 1'b0;
    int                stall_cycles = 0;
    logic [DATA_W-1:0] pa, pd;
    logic [CH_W-1:0]   pc;

    // Observe handshakes mid-cycle; inputs change only just after posedge
    always @(negedge clk) begin
        res_t r;
        if (!reset_n) begin
            model_clear();
            expq.delete();
            m_mode_q   = mode;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, out_ready || !out_valid);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_a", out_a, pa);
                chk("stall_d", out_d, pd);
                chk("stall_ch", out_ch, pc);
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                pa = out_a; pd = out_d; pc = out_ch;
                stall_cycles++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out: got a=%0d d=%0d ch=%0d required no output",
                             $signed(out_a), $signed(out_d), out_ch);
                end else begin
                    r = expq.pop_front();
                    chk("sb_a", $signed(out_a), r.a);
                    chk("sb_d", $signed(out_d), r.d);
                    chk("sb_ch", out_ch, r.ch);
                end
            end
            if (mode != m_mode_q) model_clear();
            m_mode_q = mode;
            if (in_valid && in_ready && in_ch < CHANNELS)
                model_push(int'(in_ch), longint'($signed(in_data)), mode);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct { bit m; int ch; int x; bit has; int a; int d; } vec_t;
    vec_t vecs[$];

    task automatic add(input bit m, input int ch, input int x, input bit has,
                       input int a, input int d);
        vec_t v;
        v.m = m; v.ch = ch; v.x = x; v.has = has; v.a = a; v.d = d;
        vecs.push_back(v);
    endtask

    // One sample, then check the output exactly three edges after acceptance
    task automatic apply(input int i, input vec_t v);
        mode = v.m; in_ch = CH_W'(v.ch); in_data = DATA_W'(v.x); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", i), out_valid, v.has);
        if (v.has) begin
            chk($sformatf("vec%0d_a", i), $signed(out_a), v.a);
            chk($sformatf("vec%0d_d", i), $signed(out_d), v.d);
            chk($sformatf("vec%0d_ch", i), out_ch, v.ch);
        end
    endtask

    task automatic send(input bit m, input int c, input int x);
        int n   = 0;
        bit acc = 1'b0;
        mode = m; in_ch = CH_W'(c); in_data = DATA_W'(x); in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (expq.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        add(0, 0, 10, 0, 0, 0);       add(0, 0, 20, 0, 0, 0);
        add(0, 0, 30, 1, 7, 0);       add(0, 0, 40, 0, 0, 0);
        add(0, 0, 50, 1, 21, 0);
        add(0, 1, 0, 0, 0, 0);        add(0, 1, 1000, 0, 0, 0);
        add(0, 1, 0, 1, 176, 707);    add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 176, 0);
        add(0, 2, -32768, 0, 0, 0);   add(0, 2, 32767, 0, 0, 0);
        add(0, 2, -32768, 1, -11586, 32767);
        add(1, 3, 100, 0, 0, 0);      add(1, 3, 300, 1, 282, 141);
        add(1, 3, -200, 0, 0, 0);     add(1, 3, 100, 1, -71, 212);
        add(0, 0, 10, 0, 0, 0);       add(0, 1, 0, 0, 0, 0);
        add(0, 0, 20, 0, 0, 0);       add(0, 1, 1000, 0, 0, 0);
        add(0, 0, 30, 1, 7, 0);       add(0, 5, 77, 0, 0, 0);
        add(0, 1, 0, 1, 176, 707);    add(0, 0, 40, 0, 0, 0);
        add(0, 4, 9, 0, 0, 0);        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 50, 1, 21, 0);      add(0, 1, 0, 1, 176, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_a", out_a, 0);
        chk("rst_d", out_d, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
        drain();

        // Mode toggle with a lifting pair still in flight
        send(0, 2, 10); send(0, 2, 20); send(0, 2, 30);
        send(1, 2, 100); send(1, 2, 300);
        send(0, 2, 7);
        drain();

        // Backpressure: output held for several cycles with a pair pending
        stall_cycles = 0;
        send(0, 1, 5); send(0, 1, 15);
        out_ready = 1'b0;
        fork
            begin repeat (12) @(posedge clk); #1; out_ready = 1'b1; end
        join_none
        send(0, 1, 25); send(0, 1, 35); send(0, 1, 45); send(0, 1, 55); send(0, 1, 65);
        drain();
        chk("stall_seen", stall_cycles >= 5, 1);

        // Reset mid-stream drops in-flight pairs and restarts pairing
        send(0, 0, 1); send(0, 0, 2); send(0, 0, 3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        send(0, 0, 500);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_even_idle", out_valid, 0);
        end
        send(0, 0, 600); send(0, 0, 700);
        drain();

        // Randomized traffic including bad channel tags and mode flips
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_W'($urandom_range(0, 5));
            in_data   = ($urandom_range(0, 7) == 0) ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'($urandom);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
